mem_access_arbiter: RTL and testbench

Shares the single-port data/instruction BRAM between the instruction-fetch port and the load/store port of the core. It arbitrates the two requesters and sequences the fixed RAM read latency with a valid/ready handshake, replacing the load wait-counter in the decoder. It also performs byte-lane steering for stores and lane extraction with sign or zero extension for loads.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lane_formatter.sv | 60 ++++++
 rtl/mem_access_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the BRAM access arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } mem_req_t;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam int unsigned MEM_LATENCY = 2;

endpackage

// File: rtl/mem_lane_formatter.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module mem_lane_formatter
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_we,
  output logic [31:0] st_data,
  output logic        misaligned,
  input  logic [31:0] ld_rdata,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        sign_bit;

  always_comb begin
    st_we      = 4'b0000;
    st_data    = st_wdata;
    misaligned = 1'b0;
    unique case (st_size)
      MEM_BYTE: begin
        st_we   = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      MEM_HALF: begin
        st_we      = 4'b0011 << st_off;
        st_data    = {2{st_wdata[15:0]}};
        misaligned = st_off[0];
      end
      MEM_WORD: begin
        st_we      = 4'b1111;
        misaligned = (st_off != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    shifted  = ld_rdata >> {ld_off, 3'b000};
    sign_bit = 1'b0;
    ld_data  = shifted;
    unique case (ld_size)
      MEM_BYTE: begin
        sign_bit = shifted[7] & ~ld_unsigned;
        ld_data  = {{24{sign_bit}}, shifted[7:0]};
      end
      MEM_HALF: begin
        sign_bit = shifted[15] & ~ld_unsigned;
        ld_data  = {{16{sign_bit}}, shifted[15:0]};
      end
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates instruction fetch and load/store access to one single-port BRAM and
// sequences its fixed read latency with a valid/ready handshake.
module mem_access_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WORD    = 32,
  parameter int unsigned LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [WORD-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD-1:0]   d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [WORD-1:0]   d_rdata,
  output logic              d_misaligned,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [WORD-1:0]   ram_wdata,
  input  logic [WORD-1:0]   ram_rdata
);

  localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CntW-1:0] CntInit = (LATENCY > 1) ? CntW'(LATENCY - 2) : '0;

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mem_req_t        last_q, id_q;
  logic [1:0]      off_q, size_q;
  logic            uns_q, mis_q;

  logic              idle, grant_d, grant_if, d_ok, read_start, mis;
  logic [ADDR_W-1:0] addr_sel;
  logic [3:0]        fmt_we;
  logic [31:0]       fmt_wdata, fmt_rdata;

  mem_lane_formatter u_fmt (
    .st_size     (d_size),
    .st_off      (d_addr[1:0]),
    .st_wdata    (d_wdata),
    .st_we       (fmt_we),
    .st_data     (fmt_wdata),
    .misaligned  (mis),
    .ld_rdata    (ram_rdata),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (fmt_rdata)
  );

  // Data wins a conflict unless it was the last requester granted.
  always_comb begin
    idle       = (state_q == IDLE);
    grant_d    = rst_n && idle && d_req && (!if_req || (last_q == REQ_IF));
    grant_if   = rst_n && idle && if_req && !grant_d;
    d_ok       = grant_d && !mis;
    read_start = grant_if || (d_ok && !d_we);
    addr_sel   = grant_d ? d_addr : if_addr;
  end

  always_comb begin
    if_ready  = grant_if;
    d_ready   = grant_d;
    ram_en    = grant_if || d_ok;
    ram_we    = (d_ok && d_we) ? fmt_we : 4'b0000;
    ram_wdata = (d_ok && d_we) ? fmt_wdata : '0;
    ram_addr  = ram_en ? addr_sel[ADDR_W-1:2] : '0;
    if_rvalid = (state_q == RESP) && (id_q == REQ_IF);
    d_rvalid  = (state_q == RESP) && (id_q == REQ_D);
    if_rdata  = if_rvalid ? ram_rdata : '0;
    d_rdata   = d_rvalid ? fmt_rdata : '0;
    d_misaligned = mis_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (read_start) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= REQ_IF;
      id_q    <= REQ_IF;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= grant_d && mis;
      if (grant_d)       last_q <= REQ_D;
      else if (grant_if) last_q <= REQ_IF;
      if (read_start) begin
        id_q   <= grant_d ? REQ_D : REQ_IF;
        off_q  <= addr_sel[1:0];
        size_q <= grant_d ? d_size : MEM_WORD;
        uns_q  <= grant_d && d_unsigned;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter with a 2-cycle-latency RAM model.
module tb_mem_access_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_unsigned;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_ready, d_rvalid, d_misaligned;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_size       (d_size),
    .d_unsigned   (d_unsigned),
    .d_ready      (d_ready),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .d_misaligned (d_misaligned),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // RAM model: byte-enabled writes, read data visible two cycles after ram_en.
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] rd0 = 32'h0;
  logic [31:0] rd1 = 32'h0;
  logic [7:0]  idx;
  assign idx       = 8'(ram_addr % 30'd256);
  assign ram_rdata = rd1;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[idx][i*8 +: 8] <= ram_wdata[i*8 +: 8];
      rd0 <= mem[idx];
    end
    rd1 <= rd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd);
    d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_size = size; d_wdata = wdata;
    d_unsigned = 1'b0;
    #1;
    check({tag, ".ready"}, 32'(d_ready), 32'd1);
    check({tag, ".en"}, 32'(ram_en), 32'd1);
    check({tag, ".we"}, 32'(ram_we), 32'(exp_we));
    check({tag, ".wdata"}, ram_wdata, exp_wd);
    check({tag, ".addr"}, 32'(ram_addr), {2'b00, addr[31:2]});
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] exp);
    d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_size = size; d_unsigned = uns;
    #1;
    check({tag, ".ready"}, 32'(d_ready), 32'd1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    check({tag, ".early"}, {31'd0, d_rvalid}, 32'd0);
    @(negedge clk);
    #1;
    check({tag, ".rvalid"}, 32'(d_rvalid), 32'd1);
    check({tag, ".rdata"}, d_rdata, exp);
    @(negedge clk);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    if_req = 1'b1; if_addr = addr;
    #1;
    check({tag, ".ready"}, 32'(if_ready), 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    #1;
    check({tag, ".rvalid"}, 32'(if_rvalid), 32'd1);
    check({tag, ".rdata"}, if_rdata, exp);
    @(negedge clk);
  endtask

  task automatic do_misaligned(input string tag, input logic [31:0] addr, input logic [1:0] size,
                               input logic we);
    d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_wdata = 32'hFFFF_FFFF;
    #1;
    check({tag, ".ready"}, 32'(d_ready), 32'd1);
    check({tag, ".en"}, 32'(ram_en), 32'd0);
    check({tag, ".we"}, 32'(ram_we), 32'd0);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    #1;
    check({tag, ".pulse"}, 32'(d_misaligned), 32'd1);
    check({tag, ".norv1"}, 32'(d_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, ".pulse_end"}, 32'(d_misaligned), 32'd0);
    check({tag, ".norv2"}, 32'(d_rvalid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bit exp_d;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h0;
    d_size = MEM_WORD; d_unsigned = 1'b0;
    #3;
    check("rst.if_ready", 32'(if_ready), 32'd0);
    check("rst.d_ready", 32'(d_ready), 32'd0);
    check("rst.ram_en", 32'(ram_en), 32'd0);
    check("rst.ram_we", 32'(ram_we), 32'd0);
    check("rst.rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    check("rst.mis", 32'(d_misaligned), 32'd0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_store("sw_init0", 32'h40, MEM_WORD, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store("sw_init1", 32'h80, MEM_WORD, 32'h80FF_7F01, 4'b1111, 32'h80FF_7F01);

    // Fetch with request held through the read to show ready stays low.
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    check("fetch.ready_n", 32'(if_ready), 32'd1);
    check("fetch.ram_en", 32'(ram_en), 32'd1);
    check("fetch.ram_addr", 32'(ram_addr), 32'h10);
    check("fetch.ram_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    #1;
    check("fetch.ready_n1", 32'(if_ready), 32'd0);
    check("fetch.rvalid_n1", 32'(if_rvalid), 32'd0);
    check("fetch.rdata_n1", if_rdata, 32'd0);
    @(negedge clk);
    #1;
    check("fetch.ready_n2", 32'(if_ready), 32'd0);
    check("fetch.rvalid_n2", 32'(if_rvalid), 32'd1);
    check("fetch.rdata_n2", if_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    if_req = 1'b0;

    do_load("lb_off1", 32'h81, MEM_BYTE, 1'b0, 32'h0000_007F);
    do_load("lb_off3", 32'h83, MEM_BYTE, 1'b0, 32'hFFFF_FF80);
    do_load("lbu_off2", 32'h82, MEM_BYTE, 1'b1, 32'h0000_00FF);
    do_load("lhu_off2", 32'h82, MEM_HALF, 1'b1, 32'h0000_80FF);
    do_load("lh_off2", 32'h82, MEM_HALF, 1'b0, 32'hFFFF_80FF);

    do_store("sh_off2", 32'h102, MEM_HALF, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store("sb_off1", 32'h101, MEM_BYTE, 32'h0000_0055, 4'b0010, 32'h5555_5555);
    do_load("lw_back", 32'h100, MEM_WORD, 1'b0, 32'hABCD_5500);

    do_misaligned("mis_lw", 32'h102, MEM_WORD, 1'b0);
    do_misaligned("mis_sh", 32'h101, MEM_HALF, 1'b1);
    do_misaligned("mis_sz3", 32'h100, 2'd3, 1'b0);

    // Leave fetch as last grant so data wins the first conflict.
    do_fetch("pre_conflict", 32'h40, 32'hDEAD_BEEF);

    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_size = MEM_WORD; d_unsigned = 1'b0;
    for (int t = 0; t < 8; t++) begin
      exp_d = (t % 2 == 0);
      #1;
      check($sformatf("conf%0d.d_ready", t), 32'(d_ready), 32'(exp_d));
      check($sformatf("conf%0d.if_ready", t), 32'(if_ready), 32'(!exp_d));
      @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("conf%0d.d_rdata", t), d_rdata, exp_d ? 32'h80FF_7F01 : 32'h0);
      check($sformatf("conf%0d.if_rdata", t), if_rdata, exp_d ? 32'h0 : 32'hDEAD_BEEF);
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Reset while the read is in WAIT.
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    check("rmid.grant", 32'(if_ready), 32'd1);
    @(negedge clk);
    d_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rmid.if_ready", 32'(if_ready), 32'd0);
    check("rmid.d_ready", 32'(d_ready), 32'd0);
    check("rmid.ram_en", 32'(ram_en), 32'd0);
    check("rmid.ram_addr", 32'(ram_addr), 32'd0);
    check("rmid.rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("rmid.stale%0d", c), {30'd0, if_rvalid, d_rvalid}, 32'd0);
      @(negedge clk);
    end
    do_fetch("post_reset", 32'h40, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
